// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC stall/redirect and pipeline-register hazard control
// Captures redirects during memory freezes and replays them once; detects load-use.
module pc_redirect_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imem_ready,
   input  logic             dmem_busy,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_branch_taken,
   input  logic [31:0]      ex_branch_target,
   input  logic             id_jump,
   input  logic [31:0]      id_jump_target,
   output logic             pc_stall,
   output logic             pc_shift_enable,
   output logic [31:0]      pc_shift_addr,
   output logic             pc_jump_enable,
   output logic [31:0]      pc_jump_addr,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             id_ex_flush,
   output logic             redirect_pending,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_count
);

   typedef enum logic {RUN, PEND} state_t;

   localparam logic KIND_BRANCH = 1'b0;
   localparam logic KIND_JUMP   = 1'b1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t      state, state_nxt;
   logic        pend_kind, kind_nxt;
   logic [31:0] pend_target, target_nxt;
   logic        freeze;
   logic        load_use;

   assign freeze   = dmem_busy | ~imem_ready;
   assign load_use = ex_mem_read & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

   assign redirect_pending = (state == PEND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         pend_kind   <= KIND_BRANCH;
         pend_target <= 32'd0;
      end else begin
         state       <= state_nxt;
         pend_kind   <= kind_nxt;
         pend_target <= target_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      kind_nxt        = pend_kind;
      target_nxt      = pend_target;
      pc_stall        = 1'b0;
      pc_shift_enable = 1'b0;
      pc_shift_addr   = 32'd0;
      pc_jump_enable  = 1'b0;
      pc_jump_addr    = 32'd0;
      if_id_stall     = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_bubble    = 1'b0;
      id_ex_flush     = 1'b0;
      // Outputs stay quiet for the whole time rst_n is held low.
      if (rst_n) begin
         case (state)
            RUN: begin
               if (freeze) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  if (ex_branch_taken) begin
                     kind_nxt   = KIND_BRANCH;
                     target_nxt = ex_branch_target;
                     state_nxt  = PEND;
                  end else if (id_jump && !load_use) begin
                     kind_nxt   = KIND_JUMP;
                     target_nxt = id_jump_target;
                     state_nxt  = PEND;
                  end
               end else if (ex_branch_taken) begin
                  pc_shift_enable = 1'b1;
                  pc_shift_addr   = ex_branch_target;
                  if_id_flush     = 1'b1;
                  id_ex_flush     = 1'b1;
               end else if (load_use) begin
                  pc_stall     = 1'b1;
                  if_id_stall  = 1'b1;
                  id_ex_bubble = 1'b1;
               end else if (id_jump) begin
                  pc_jump_enable = 1'b1;
                  pc_jump_addr   = id_jump_target;
                  if_id_flush    = 1'b1;
               end
            end
            PEND: begin
               // Live redirect inputs come from the same frozen instruction; ignore them.
               if (freeze) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
               end else begin
                  state_nxt = RUN;
                  if (pend_kind == KIND_BRANCH) begin
                     pc_shift_enable = 1'b1;
                     pc_shift_addr   = pend_target;
                     if_id_flush     = 1'b1;
                     id_ex_flush     = 1'b1;
                  end else begin
                     pc_jump_enable = 1'b1;
                     pc_jump_addr   = pend_target;
                     if_id_flush    = 1'b1;
                  end
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles   <= '0;
         redirect_count <= '0;
      end else begin
         if (pc_stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_ONE;
         if ((pc_shift_enable || pc_jump_enable) && (redirect_count != '1))
            redirect_count <= redirect_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - scoreboard bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

   localparam logic [7:0] E_STALL = 8'h80;
   localparam logic [7:0] E_SEN   = 8'h40;
   localparam logic [7:0] E_JEN   = 8'h20;
   localparam logic [7:0] E_IFS   = 8'h10;
   localparam logic [7:0] E_IFF   = 8'h08;
   localparam logic [7:0] E_BUB   = 8'h04;
   localparam logic [7:0] E_EXF   = 8'h02;
   localparam logic [7:0] E_PEND  = 8'h01;
   localparam logic [7:0] E_FRZ   = E_STALL | E_IFS;
   localparam logic [7:0] E_LU    = E_STALL | E_IFS | E_BUB;
   localparam logic [7:0] E_BR    = E_SEN | E_IFF | E_EXF;
   localparam logic [7:0] E_JP    = E_JEN | E_IFF;

   typedef struct packed {
      logic [7:0]  bits;
      logic [31:0] saddr;
      logic [31:0] jaddr;
      logic [31:0] stall_cnt;
      logic [31:0] redir_cnt;
      logic [3:0]  sat_cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_ready = 1'b0, dmem_busy = 1'b0, ex_mem_read = 1'b0;
   logic [4:0]  ex_rt = '0, id_rs = '0, id_rt = '0;
   logic        id_uses_rt = 1'b0, ex_branch_taken = 1'b0, id_jump = 1'b0;
   logic [31:0] ex_branch_target = '0, id_jump_target = '0;

   logic        pc_stall, pc_shift_enable, pc_jump_enable;
   logic [31:0] pc_shift_addr, pc_jump_addr;
   logic        if_id_stall, if_id_flush, id_ex_bubble, id_ex_flush, redirect_pending;
   logic [31:0] stall_cycles, redirect_count;

   logic        s_stall, s_sen, s_jen, s_ifs, s_iff, s_bub, s_exf, s_pend;
   logic [31:0] s_saddr, s_jaddr;
   logic [3:0]  s_stall_cycles, s_redirect_count;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] m_stall = 0, m_redir = 0;
   logic [3:0]  m_sat = 0;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(.CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
      .ex_branch_target(ex_branch_target), .id_jump(id_jump),
      .id_jump_target(id_jump_target), .pc_stall(pc_stall),
      .pc_shift_enable(pc_shift_enable), .pc_shift_addr(pc_shift_addr),
      .pc_jump_enable(pc_jump_enable), .pc_jump_addr(pc_jump_addr),
      .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .id_ex_flush(id_ex_flush),
      .redirect_pending(redirect_pending), .stall_cycles(stall_cycles),
      .redirect_count(redirect_count)
   );

   pc_redirect_ctrl #(.CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
      .ex_branch_target(ex_branch_target), .id_jump(id_jump),
      .id_jump_target(id_jump_target), .pc_stall(s_stall),
      .pc_shift_enable(s_sen), .pc_shift_addr(s_saddr),
      .pc_jump_enable(s_jen), .pc_jump_addr(s_jaddr),
      .if_id_stall(s_ifs), .if_id_flush(s_iff),
      .id_ex_bubble(s_bub), .id_ex_flush(s_exf),
      .redirect_pending(s_pend), .stall_cycles(s_stall_cycles),
      .redirect_count(s_redirect_count)
   );

   task automatic step(input logic rst, input logic imr, input logic dmb,
                       input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt,
                       input logic bt, input logic [31:0] btgt,
                       input logic jp, input logic [31:0] jtgt,
                       input logic [7:0] ebits, input logic [31:0] esaddr,
                       input logic [31:0] ejaddr);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rst; imem_ready = imr; dmem_busy = dmb; ex_mem_read = mr;
      ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt;
      ex_branch_taken = bt; ex_branch_target = btgt;
      id_jump = jp; id_jump_target = jtgt;
      if (!rst) begin
         m_stall = 0; m_redir = 0; m_sat = 0;
      end
      e.bits = ebits; e.saddr = esaddr; e.jaddr = ejaddr;
      e.stall_cnt = m_stall; e.redir_cnt = m_redir; e.sat_cnt = m_sat;
      sb.push_back(e);
      if ((ebits & E_STALL) != 0) begin
         m_stall = m_stall + 1;
         if (m_sat != 4'hF) m_sat = m_sat + 4'd1;
      end
      if ((ebits & (E_SEN | E_JEN)) != 0) m_redir = m_redir + 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("flags", {24'd0, pc_stall, pc_shift_enable, pc_jump_enable, if_id_stall,
                       if_id_flush, id_ex_bubble, id_ex_flush, redirect_pending}, {24'd0, e.bits});
         chk("shift_addr", pc_shift_addr, e.saddr);
         chk("jump_addr", pc_jump_addr, e.jaddr);
         chk("stall_cycles", stall_cycles, e.stall_cnt);
         chk("redirect_count", redirect_count, e.redir_cnt);
         chk("sat_stall_cycles", {28'd0, s_stall_cycles}, {28'd0, e.sat_cnt});
      end
   end

   initial begin
      int budget;
      // reset then idle
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      idle(3);
      // branch taken, no freeze
      step(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0, E_BR, 32'h40, 0);
      idle(1);
      // branch captured during imem freeze, replayed once on release
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, E_FRZ, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, E_FRZ | E_PEND, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, E_FRZ | E_PEND, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, E_BR | E_PEND, 32'h80, 0);
      idle(1);
      // load-use on rs, then load moves to MEM
      step(1, 1, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0, E_LU, 0, 0);
      idle(1);
      // ex_rt = 0 never hazards
      step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      // rt match only counts when id_uses_rt
      step(1, 1, 0, 1, 7, 3, 7, 1, 0, 0, 0, 0, E_LU, 0, 0);
      step(1, 1, 0, 1, 7, 3, 7, 0, 0, 0, 0, 0, 8'h00, 0, 0);
      // branch beats load-use and jump
      step(1, 1, 0, 1, 5, 5, 0, 0, 1, 32'h100, 1, 32'h200, E_BR, 32'h100, 0);
      // plain jump
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, E_JP, 0, 32'h300);
      // load-use beats jump
      step(1, 1, 0, 1, 5, 5, 0, 0, 0, 0, 1, 32'h304, E_LU, 0, 0);
      // jump with load-use under freeze is not captured
      step(1, 0, 0, 1, 5, 5, 0, 0, 0, 0, 1, 32'h308, E_FRZ, 0, 0);
      idle(1);
      // jump captured under dmem freeze, then reset drops it
      step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, E_FRZ, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, E_FRZ | E_PEND, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 8'h00, 0, 0);
      idle(2);
      // jump captured under dmem freeze, replayed on release
      step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h500, E_FRZ, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h500, E_JP | E_PEND, 0, 32'h500);
      idle(1);
      // 20 stall cycles saturate the 4-bit counter at 15
      for (int i = 0; i < 20; i++)
         step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FRZ, 0, 0);
      idle(2);

      budget = 0;
      while (sb.size() != 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Hazard and redirect controller that drives the PC's stall, shift (branch) and jump controls, plus the IF/ID and ID/EX pipeline-register controls, for the 5-stage MIPS pipeline.
- The PC ignores shift/jump requests while stall is high. This block therefore captures any redirect that arrives during a memory freeze and replays it exactly once when the freeze releases.
- It also detects load-use hazards and keeps saturating performance counters.

Parameters:
- CNT_W, 32, width of stall_cycles and redirect_count counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- imem_ready  in  1  instruction fetch completes this cycle.
- dmem_busy  in  1  data memory busy; freezes the whole pipe.
- ex_mem_read  in  1  EX-stage instruction is a load.
- ex_rt  in  5  load destination register in EX.
- id_rs  in  5  ID-stage source register rs.
- id_rt  in  5  ID-stage source register rt.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_branch_taken  in  1  taken branch resolved in EX.
- ex_branch_target  in  32  branch target address.
- id_jump  in  1  jump decoded in ID.
- id_jump_target  in  32  jump target address.
- pc_stall  out  1  to PC stall.
- pc_shift_enable  out  1  to PC shift_enable.
- pc_shift_addr  out  32  to PC shift_inst_addr.
- pc_jump_enable  out  1  to PC jump_enable.
- pc_jump_addr  out  32  to PC jump_inst_addr.
- if_id_stall  out  1  hold IF/ID register.
- if_id_flush  out  1  clear IF/ID register at this edge.
- id_ex_bubble  out  1  insert NOP into ID/EX.
- id_ex_flush  out  1  clear ID/EX register at this edge.
- redirect_pending  out  1  a captured redirect awaits replay.
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1.
- redirect_count  out  CNT_W  count of redirects issued.

Behaviour:
- Reset
  - rst_n low clears pend_valid, pend_kind, pend_target and both counters immediately, without waiting for a clock edge.
  - While rst_n is low, all 1-bit outputs are 0, and pc_shift_addr and pc_jump_addr are 0.
- Derived signals (combinational)
  - freeze = dmem_busy | ~imem_ready.
  - load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- States: RUN (pend_valid=0) and PEND (pend_valid=1). redirect_pending = pend_valid.
- RUN, freeze=1
  - Drive pc_stall=1 and if_id_stall=1. All enables and flushes are 0.
  - If ex_branch_taken: capture kind=branch and target=ex_branch_target, then go to PEND.
  - Else if id_jump and not load_use: capture kind=jump and target=id_jump_target, then go to PEND.
- RUN, freeze=0, with priority branch > load_use > jump:
  - Branch: pc_shift_enable=1, pc_shift_addr=ex_branch_target, if_id_flush=1, id_ex_flush=1. A simultaneous id_jump is discarded because it is on the wrong path.
  - load_use: pc_stall=1, if_id_stall=1, id_ex_bubble=1. Exactly one bubble per hazard; the next cycle sees the load in MEM, so load_use drops.
  - Jump: pc_jump_enable=1, pc_jump_addr=id_jump_target, if_id_flush=1.
  - None of the above: all outputs 0, and the PC increments by 4.
- PEND
  - Live ex_branch_taken and id_jump are ignored, because the same frozen instruction keeps asserting them.
  - While freeze=1: pc_stall=1 and if_id_stall=1.
  - First cycle with freeze=0: replay the pending redirect on the channel matching pend_kind, with its flushes exactly as in RUN, then clear pend_valid and return to RUN.
- Outputs are combinational from state and inputs, and are valid in the same cycle. The PC registers the redirect at the next edge, so redirect latency is 1 cycle.
- Addresses pass through unmodified; the block does no alignment checking.
- Counters
  - stall_cycles increments on every edge where pc_stall=1.
  - redirect_count increments on every edge where pc_shift_enable or pc_jump_enable is 1.
  - Both saturate at all-ones and never wrap.
- A reset asserted while in PEND drops the pending redirect; there is no replay after reset.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then imem_ready=1 -> all outputs 0; counters 0; PC sequence 0x0, 0x4, 0x8.
- Branch taken with no freeze: ex_branch_taken=1, target 0x40 for 1 cycle -> same cycle pc_shift_enable=1, pc_shift_addr=0x40, if_id_flush=1, id_ex_flush=1; PC=0x40 next cycle; redirect_count=1.
- Branch during freeze: imem_ready=0 for 3 cycles with ex_branch_taken=1, target 0x80 -> pc_stall=1 for 3 cycles, redirect_pending=1, no enables; first cycle with imem_ready=1 gives pc_shift_enable=1 with addr 0x80 exactly once; stall_cycles=3, redirect_count=1.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> exactly one cycle of pc_stall, if_id_stall and id_ex_bubble; the same with ex_rt=0 gives no stall.
- Branch, jump and load_use all asserted together: branch 0x100, jump 0x200 -> only pc_shift_enable with addr 0x100; pc_jump_enable=0, pc_stall=0.
- Reset in PEND, then saturation: capture a jump under freeze, pulse rst_n low -> redirect_pending=0, no replay afterwards; with CNT_W=4 and 20 stall cycles, stall_cycles holds at 15.
